ysyx_22041211_ifu: RTL and testbench

//  Instruction fetch unit. Holds the PC and fetches one 32-bit instruction per transaction

---
 rtl/ysyx_22041211_pkg.sv | 15 +
 rtl/ysyx_22041211_pc_reg.sv | 36 +++
 rtl/ysyx_22041211_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041211_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset PC and sequential fetch step.
package ysyx_22041211_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/ysyx_22041211_pc_reg.sv
// Program counter with next-pc selection: redirect target, sequential step, or hold.
// Without YSYX_22041211_IFU_MISALIGN_EN the low two bits of a redirect target are cleared.
module ysyx_22041211_pc_reg
    import ysyx_22041211_pkg::*;
#(
    parameter int unsigned          ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0]  RESET_PC = ADDR_LEN'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    input  logic                advance,
    output logic [ADDR_LEN-1:0] pc
);

    logic [ADDR_LEN-1:0] target;

`ifdef YSYX_22041211_IFU_MISALIGN_EN
    assign target = redirect_pc;
`else
    assign target = {redirect_pc[ADDR_LEN-1:2], 2'b00};
`endif

    // Redirect beats the sequential step; the step wraps modulo 2^ADDR_LEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc + ADDR_LEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: req/resp fetch FSM, instruction buffer and redirect handling.
// Optional YSYX_22041211_IFU_MISALIGN_EN adds inst_misalign and suppresses misaligned fetches.
module ysyx_22041211_ifu
    import ysyx_22041211_pkg::*;
#(
    parameter int unsigned          DATA_LEN = 32,
    parameter int unsigned          ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0]  RESET_PC = ADDR_LEN'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [ADDR_LEN-1:0] redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_LEN-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [DATA_LEN-1:0] imem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst,
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    output logic [ADDR_LEN-1:0] inst_pc,
    output logic                inst_misalign
`else
    output logic [ADDR_LEN-1:0] inst_pc
`endif
);

    ifu_state_e          state;
    logic [ADDR_LEN-1:0] pc;
    logic                drop;
    logic                pc_adv;

`ifdef YSYX_22041211_IFU_MISALIGN_EN
    logic pc_bad;
    logic misalign_q;
    assign pc_bad         = (pc[1:0] != 2'b00);
    assign inst_misalign  = misalign_q;
    assign imem_req_valid = (state == REQ) && !pc_bad;
`else
    assign imem_req_valid = (state == REQ);
`endif

    assign imem_req_addr = pc;
    assign inst_valid    = (state == HOLD);
    assign pc_adv        = (state == HOLD) && inst_ready;

    ysyx_22041211_pc_reg #(
        .ADDR_LEN (ADDR_LEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (pc_adv),
        .pc             (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            drop    <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
`ifdef YSYX_22041211_IFU_MISALIGN_EN
                    if (pc_bad) begin
                        if (!redirect_valid) begin
                            state      <= HOLD;
                            inst       <= '0;
                            inst_pc    <= pc;
                            misalign_q <= 1'b1;
                        end
                    end else
`endif
                    // A request accepted alongside a redirect is already in flight; its reply is discarded.
                    if (imem_req_ready) begin
                        state <= WAIT;
                        drop  <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst    <= imem_resp_data;
                            inst_pc <= pc;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
                            misalign_q <= 1'b0;
`endif
                            state   <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed bench for ysyx_22041211_ifu; follows YSYX_22041211_IFU_MISALIGN_EN when defined.
module tb_ysyx_22041211_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
    logic        inst_misalign;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ysyx_22041211_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
`ifdef YSYX_22041211_IFU_MISALIGN_EN
        .inst_pc         (inst_pc),
        .inst_misalign   (inst_misalign)
`else
        .inst_pc         (inst_pc)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
        step(); step();
        n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0b exp 0", imem_req_valid); else n_pass++;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %0b exp 0", inst_valid); else n_pass++;
        n_chk++; if (inst !== 32'h0 || inst_pc !== 32'h0) $display("FAIL rst_inst got %h/%h exp 0/0", inst, inst_pc); else n_pass++;
        n_chk++; if (imem_req_addr !== 32'h8000_0000) $display("FAIL rst_pc got %h exp 80000000", imem_req_addr); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        step();
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) $display("FAIL t1_req got %0b/%h exp 1/80000000", imem_req_valid, imem_req_addr); else n_pass++;
        imem_req_ready = 1'b1;
        step();
        n_chk++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL t1_wait got iv=%0b rv=%0b exp 0/0", inst_valid, imem_req_valid); else n_pass++;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        step();
        imem_resp_valid = 1'b0;
        n_chk++; if (inst_valid !== 1'b1) $display("FAIL t1_inst_valid got %0b exp 1", inst_valid); else n_pass++;
        n_chk++; if (inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000) $display("FAIL t1_inst got %h@%h exp 00000013@80000000", inst, inst_pc); else n_pass++;
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000)
                $display("FAIL t2_stall%0d got iv=%0b rv=%0b %h@%h exp 1/0 00000013@80000000", i, inst_valid, imem_req_valid, inst, inst_pc);
            else n_pass++;
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) $display("FAIL t1_next_req got %0b/%h exp 1/80000004", imem_req_valid, imem_req_addr); else n_pass++;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL t2_consumed got %0b exp 0", inst_valid); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        n_chk++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL t3_waiting got iv=%0b rv=%0b exp 0/0", inst_valid, imem_req_valid); else n_pass++;
        step();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL t3_dropped got %0b exp 0", inst_valid); else n_pass++;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) $display("FAIL t3_req got %0b/%h exp 1/80000100", imem_req_valid, imem_req_addr); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        step();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
        step();
        imem_resp_valid = 1'b0;
        n_chk++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== 32'h8000_0100) $display("FAIL t4_hold got %0b %h@%h exp 1 00500093@80000100", inst_valid, inst, inst_pc); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; inst_ready = 1'b1; imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL t4_consumed got %0b exp 0", inst_valid); else n_pass++;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) $display("FAIL t4_req got %0b/%h exp 1/80000200", imem_req_valid, imem_req_addr); else n_pass++;
        step();
        n_chk++; if (inst_valid !== 1'b0 || imem_req_addr !== 32'h8000_0200) $display("FAIL t4_once got %0b/%h exp 0/80000200", inst_valid, imem_req_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL t5_valids got %0b/%0b exp 0/0", imem_req_valid, inst_valid); else n_pass++;
        n_chk++; if (inst !== 32'h0 || inst_pc !== 32'h0) $display("FAIL t5_inst got %h/%h exp 0/0", inst, inst_pc); else n_pass++;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
        step();
        imem_resp_valid = 1'b0;
        step();
        n_chk++; if (inst_valid !== 1'b0 || inst !== 32'h0) $display("FAIL t5_ignored got %0b/%h exp 0/0", inst_valid, inst); else n_pass++;
        rst = 1'b0;
        step();
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) $display("FAIL t5_req got %0b/%h exp 1/80000000", imem_req_valid, imem_req_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL tw_req got %0b/%h exp 1/fffffffc", imem_req_valid, imem_req_addr); else n_pass++;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0073;
        step();
        imem_resp_valid = 1'b0;
        n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) $display("FAIL tw_hold got %0b@%h exp 1@fffffffc", inst_valid, inst_pc); else n_pass++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) $display("FAIL tw_wrap got %0b/%h exp 1/00000000", imem_req_valid, imem_req_addr); else n_pass++;
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef YSYX_22041211_IFU_MISALIGN_EN
        n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL t6_noreq got %0b exp 0", imem_req_valid); else n_pass++;
        step();
        n_chk++; if (inst_valid !== 1'b1 || inst_misalign !== 1'b1) $display("FAIL t6_flag got iv=%0b mis=%0b exp 1/1", inst_valid, inst_misalign); else n_pass++;
        n_chk++; if (inst_pc !== 32'h8000_0102 || inst !== 32'h0) $display("FAIL t6_inst got %h@%h exp 0@80000102", inst, inst_pc); else n_pass++;
`else
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) $display("FAIL t6_aligned got %0b/%h exp 1/80000100", imem_req_valid, imem_req_addr); else n_pass++;
        step();
        n_chk++; if (inst_valid !== 1'b0 || imem_req_addr !== 32'h8000_0100) $display("FAIL t6_stay got %0b/%h exp 0/80000100", inst_valid, imem_req_addr); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_reset_mid();
        test_wrap();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
